// File: rtl/pixel_bus_readout.sv
// pixel_bus_readout: digital end of the shared pixel column bus.
// During convert the ramp count is driven onto every column; during a row read the bus
// is released, the selected row's latched codes are captured and queued into a small
// row FIFO that feeds a valid/ready stream.
// Optional feature: define PIXBUS_GRAY_EN to put a Gray-coded ramp on the bus; captured
// codes are then converted back to binary before they enter the FIFO.
module pixel_bus_readout #(
    parameter int H_PIXELS   = 4,
    parameter int V_PIXELS   = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          convert,
    input  logic [V_PIXELS-1:0]           read,
    inout  wire  [H_PIXELS*DATA_W-1:0]    pixData,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [H_PIXELS*DATA_W-1:0]    out_data,
    output logic [$clog2(V_PIXELS)-1:0]   out_row,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          sel_err
);

    localparam int ROW_W = $clog2(V_PIXELS);
    localparam int BUS_W = H_PIXELS * DATA_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROW_W + BUS_W;
    localparam logic [DATA_W-1:0] RAMP_MAX = '1;
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(V_PIXELS - 1);

`ifdef PIXBUS_GRAY_EN
    // Gray code keeps a pixel latch from catching a multi-bit transition mid-count.
    function automatic logic [DATA_W-1:0] bus_code(input logic [DATA_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] decode_col(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        b[DATA_W-1] = g[DATA_W-1];
        for (int i = DATA_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`else
    function automatic logic [DATA_W-1:0] bus_code(input logic [DATA_W-1:0] x);
        return x;
    endfunction

    function automatic logic [DATA_W-1:0] decode_col(input logic [DATA_W-1:0] g);
        return g;
    endfunction
`endif

    // Decode every column slice of a captured row, packing unchanged.
    function automatic logic [BUS_W-1:0] decode_row(input logic [BUS_W-1:0] raw);
        logic [BUS_W-1:0] res;
        res = '0;
        for (int c = 0; c < H_PIXELS; c++) begin
            res[c*DATA_W +: DATA_W] = decode_col(raw[c*DATA_W +: DATA_W]);
        end
        return res;
    endfunction

    // One-hot row select to row index.
    function automatic logic [ROW_W-1:0] row_index(input logic [V_PIXELS-1:0] onehot);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < V_PIXELS; i++) begin
            if (onehot[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

    logic [DATA_W-1:0]   ramp_q, ramp_d;
    logic [V_PIXELS-1:0] rd_last_q;
    logic                bad_q;
    logic [BUS_W-1:0]    hold_q;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                frame_done_q, overflow_q, sel_err_q;

    logic any_read, multi_read, fall, push_req, full, empty, pop, push, drop;
    logic [ROW_W-1:0] push_row;

    // Bus is driven only while no row is selected and reset is low; release is immediate.
    assign pixData = (!(|read) && !reset) ? {H_PIXELS{bus_code(ramp_q)}} : {BUS_W{1'bz}};

    // Next-state for ramp, read-pulse tracking and FIFO bookkeeping.
    always_comb begin
        any_read   = |read;
        multi_read = |(read & (read - V_PIXELS'(1)));
        fall       = !any_read && (|rd_last_q);
        push_req   = fall && !bad_q;
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        empty      = (count_q == '0);
        pop        = !empty && out_ready;
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        push_row   = row_index(rd_last_q);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        ramp_d     = '0;
        if (convert) begin
            ramp_d = (ramp_q == RAMP_MAX) ? ramp_q : ramp_q + DATA_W'(1);
        end
    end

    // Control state: ramp counter, read tracking, FIFO pointers and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_q       <= '0;
            rd_last_q    <= '0;
            bad_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            ramp_q  <= ramp_d;
            count_q <= count_d;
            if (any_read) begin
                rd_last_q <= read;
                if (multi_read) bad_q <= 1'b1;
            end else begin
                rd_last_q <= '0;
                bad_q     <= 1'b0;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            frame_done_q <= push && (push_row == LAST_ROW);
            if (drop)       overflow_q <= 1'b1;
            if (multi_read) sel_err_q  <= 1'b1;
        end
    end

    // Row capture from the released bus while a row is selected.
    always_ff @(posedge clk) begin
        if (any_read) hold_q <= pixData;
    end

    // FIFO storage write of the decoded row and its index.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_row, decode_row(hold_q)};
    end

    assign out_valid        = !empty;
    assign {out_row, out_data} = empty ? {ENT_W{1'b0}} : mem_q[rd_ptr_q];
    assign frame_done       = frame_done_q;
    assign overflow         = overflow_q;
    assign sel_err          = sel_err_q;

endmodule

// File: tb/tb_pixel_bus_readout.sv
`timescale 1ns/1ps
// tb_pixel_bus_readout: table vectors, directed corner sequences and random stimulus
// against a queue-based reference model of the readout.
module tb_pixel_bus_readout;
    localparam int H = 4, V = 4, DW = 8, DEPTH = 4, BW = H * DW, RW = 2;

    logic          clk = 1'b0, reset = 1'b0, convert = 1'b0, out_ready = 1'b0;
    logic [V-1:0]  read = '0;
    logic [BW-1:0] tb_val = '0;
    wire  [BW-1:0] pixData;
    logic          out_valid, frame_done, overflow, sel_err;
    logic [BW-1:0] out_data;
    logic [RW-1:0] out_row;

    assign pixData = ((read != '0) || reset) ? tb_val : {BW{1'bz}};

    always #5 clk = ~clk;

    pixel_bus_readout #(.H_PIXELS(H), .V_PIXELS(V), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .convert(convert), .read(read), .pixData(pixData),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .frame_done(frame_done), .overflow(overflow), .sel_err(sel_err)
    );

    int checks = 0, errors = 0, fd_seen = 0;
    int popped[$];

    typedef struct { logic [RW-1:0] row; logic [BW-1:0] data; } entry_t;
    entry_t        mq[$];
    int            m_ramp;
    bit            m_pend, m_bad, m_fd, m_ovf, m_sel;
    logic [V-1:0]  m_prow;
    logic [BW-1:0] m_pdata;

    function automatic logic [DW-1:0] code(input int x);
`ifdef PIXBUS_GRAY_EN
        return DW'(x ^ (x >> 1));
`else
        return DW'(x);
`endif
    endfunction

    function automatic logic [BW-1:0] bus_of(input int x);
        return {H{code(x)}};
    endfunction

    function automatic logic [BW-1:0] decode(input logic [BW-1:0] b);
`ifdef PIXBUS_GRAY_EN
        logic [BW-1:0] r;
        logic [DW-1:0] g, v;
        r = '0;
        for (int c = 0; c < H; c++) begin
            g = b[c*DW +: DW];
            v = '0;
            for (int k = 0; k < DW; k++) v ^= g >> k;
            r[c*DW +: DW] = v;
        end
        return r;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ramp = 0; m_pend = 0; m_bad = 0; m_fd = 0; m_ovf = 0; m_sel = 0;
        m_prow = '0; m_pdata = '0;
    endtask

    // Reference behaviour for one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        entry_t e;
        bit pop;
        pop  = (mq.size() != 0) && out_ready;
        m_fd = 0;
        if (pop) void'(mq.pop_front());
        if (read == '0 && m_pend) begin
            if (!m_bad) begin
                if (mq.size() == DEPTH) m_ovf = 1;
                else begin
                    e.row  = RW'($clog2(m_prow));
                    e.data = decode(m_pdata);
                    mq.push_back(e);
                    m_fd = (e.row == RW'(V - 1));
                end
            end
            m_pend = 0; m_bad = 0;
        end else if (read != '0) begin
            m_pend = 1; m_prow = read; m_pdata = tb_val;
            if ($countones(read) > 1) begin m_bad = 1; m_sel = 1; end
        end
        m_ramp = convert ? ((m_ramp < 255) ? m_ramp + 1 : 255) : 0;
    endtask

    task automatic compare_model();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_row", 64'(out_row), 64'(mq[0].row));
            chk("out_data", 64'(out_data), 64'(mq[0].data));
        end
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("sel_err", 64'(sel_err), 64'(m_sel));
        if (read == '0 && !reset) chk("pixData_drive", 64'(pixData), 64'(bus_of(m_ramp)));
        else                      chk("pixData_release", 64'(pixData), 64'(tb_val));
        if (frame_done) fd_seen++;
    endtask

    task automatic step();
        if (out_valid && out_ready) popped.push_back(int'(out_row));
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_model();
        @(posedge clk);
        #1;
        compare_model();
        read = '0; convert = 1'b0;
        reset = 1'b0;
        #1;
    endtask

    task automatic read_row(input int r);
        read   = V'(1 << r);
        tb_val = $urandom;
        step();
        read = '0;
        step();
    endtask

    typedef struct {
        logic          conv;
        logic [V-1:0]  rd;
        logic [BW-1:0] bus;
        logic          rdy;
        logic          ev;
        logic [RW-1:0] er;
        logic [BW-1:0] ed;
        logic          es;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 4'b0100, 32'h11223344, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 4'b0100, 32'h11223344, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd2, 32'h11223344, 1'b0};
        tbl[3] = '{1'b1, 4'b0000, 32'h0,        1'b0, 1'b1, 2'd2, 32'h11223344, 1'b0};
        tbl[4] = '{1'b1, 4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0, 1'b0};
        tbl[5] = '{1'b0, 4'b0011, 32'hAABBCCDD, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1};
        tbl[6] = '{1'b0, 4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0, 1'b1};
        tbl[7] = '{1'b0, 4'b0001, 32'h01020304, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, 32'h0,        1'b1, 1'b1, 2'd0, 32'h01020304, 1'b1};
        tbl[9] = '{1'b0, 4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0, 1'b1};

        // Reset values
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_row", 64'(out_row), 64'(0));
        chk("rst_fd", 64'(frame_done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_sel", 64'(sel_err), 64'(0));

        // Ramp count, saturation and clear
        convert = 1'b1;
        repeat (10) step();
`ifdef PIXBUS_GRAY_EN
        chk("ramp10", 64'(pixData), 64'(32'h0F0F0F0F));
`else
        chk("ramp10", 64'(pixData), 64'(32'h0A0A0A0A));
`endif
        repeat (300) step();
`ifdef PIXBUS_GRAY_EN
        chk("ramp_sat", 64'(pixData), 64'(32'h80808080));
`else
        chk("ramp_sat", 64'(pixData), 64'(32'hFFFFFFFF));
`endif
        convert = 1'b0;
        step();
        chk("ramp_clr", 64'(pixData), 64'(0));

        // Table vectors: single row read, select error, next row
        do_reset();
        foreach (tbl[i]) begin
            convert = tbl[i].conv; read = tbl[i].rd; tb_val = tbl[i].bus; out_ready = tbl[i].rdy;
            #1;
            if (tbl[i].rd != '0) chk("tbl_release_now", 64'(pixData), 64'(tbl[i].bus));
            step();
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_row", 64'(out_row), 64'(tbl[i].er));
                chk("tbl_data", 64'(out_data), 64'(decode(tbl[i].ed)));
            end
            chk("tbl_sel", 64'(sel_err), 64'(tbl[i].es));
        end

        // Full frame with consumer always ready
        do_reset();
        out_ready = 1'b1; popped.delete(); fd_seen = 0;
        for (int r = 0; r < V; r++) read_row(r);
        step(); step();
        chk("frame_words", 64'(popped.size()), 64'(4));
        foreach (popped[i]) chk("frame_order", 64'(popped[i]), 64'(i));
        chk("frame_done_pulses", 64'(fd_seen), 64'(1));
        chk("frame_ovf", 64'(overflow), 64'(0));

        // Overflow with stalled consumer, then drain
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) read_row(r % V);
        chk("ovf_set", 64'(overflow), 64'(1));
        popped.delete(); out_ready = 1'b1;
        repeat (6) step();
        chk("ovf_drain_n", 64'(popped.size()), 64'(4));
        foreach (popped[i]) chk("ovf_drain_order", 64'(popped[i]), 64'(i));
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Select error, then reset in the middle of a read
        do_reset();
        read = 4'b0011; tb_val = $urandom; step();
        read = '0; step();
        chk("sel_set", 64'(sel_err), 64'(1));
        chk("sel_nopush", 64'(out_valid), 64'(0));
        read = 4'b0100; tb_val = $urandom; step();
        do_reset();
        chk("midrst_sel", 64'(sel_err), 64'(0));
        chk("midrst_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b0;
        repeat (3) step();
        chk("midrst_nopush", 64'(out_valid), 64'(0));

        // Push and pop on the same edge while full
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < V; r++) read_row(r);
        read = 4'b0001; tb_val = $urandom; step();
        read = '0; out_ready = 1'b1; popped.delete();
        step();
        chk("pp_noovf", 64'(overflow), 64'(0));
        chk("pp_valid", 64'(out_valid), 64'(1));
        repeat (6) step();
        chk("pp_count", 64'(popped.size()), 64'(5));
        foreach (popped[i]) chk("pp_order", 64'(popped[i]), 64'(i % V));

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int sel;
            convert   = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            sel       = int'($urandom % 10);
            if (read != '0 && ($urandom % 2) == 0) read = '0;
            else if (sel < 6)  read = '0;
            else if (sel < 9)  read = V'(1 << ($urandom % V));
            else               read = V'($urandom);
            tb_val = $urandom;
            step();
            if (($urandom % 200) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
